// File: rtl/pb_mcast_unicast_sequencer.sv
// rtl/pb_mcast_unicast_sequencer.sv - expands one multicast request into a serial unicast address stream
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i/in_ready_o   request handshake (ready only while idle)
//   in_addr_i, in_mask_i    base address and multicast mask (1 = enumerated bit)
//   out_valid_o/out_ready_i unicast beat handshake, one beat per cycle
//   out_addr_o, out_last_o  unicast address, final beat of the request
//   busy_o                  request in progress
//   err_o                   one-cycle pulse: illegal request dropped
module pb_mcast_unicast_sequencer #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned YOffset   = 18,
    parameter int unsigned YLen      = 2,
    parameter int unsigned XOffset   = 20,
    parameter int unsigned XLen      = 2,
    parameter int unsigned NumX      = 4,
    parameter int unsigned NumY      = 4,
    parameter logic [AddrWidth-1:0] McastStart = 'h2000_0000,
    parameter logic [AddrWidth-1:0] McastEnd   = 'h2040_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic [AddrWidth-1:0] in_mask_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 err_o
);

    typedef enum logic {
        Idle,
        Emit
    } state_t;

    localparam logic [XLen-1:0] XOne = 1;
    localparam logic [YLen-1:0] YOne = 1;

    state_t                 state_q;
    logic [AddrWidth-1:0]   base_q;
    logic [XLen-1:0]        mx_q, cx_q;
    logic [YLen-1:0]        my_q, cy_q;
    logic                   err_q;

    // Only the coordinate fields of the mask matter; every other mask bit is ignored.
    logic [XLen-1:0] in_mx, in_bx;
    logic [YLen-1:0] in_my, in_by;
    logic            unused_mask;
    assign in_mx       = in_mask_i[XOffset+:XLen];
    assign in_my       = in_mask_i[YOffset+:YLen];
    assign in_bx       = in_addr_i[XOffset+:XLen];
    assign in_by       = in_addr_i[YOffset+:YLen];
    assign unused_mask = ^in_mask_i;

    // A request with no enumerated field bits is a plain unicast and is never rejected.
    // Otherwise the highest coordinate reachable is (base | mask), so checking it once at
    // accept covers every beat of the expansion.
    logic legal;
    always_comb begin
        legal = 1'b0;
        if (in_mx == '0 && in_my == '0) begin
            legal = 1'b1;
        end else if (in_addr_i >= McastStart && in_addr_i < McastEnd &&
                     32'(in_bx | in_mx) < NumX && 32'(in_by | in_my) < NumY) begin
            legal = 1'b1;
        end
    end

    // Masked increment: forcing the non-enumerated bits to 1 lets the carry ripple only
    // through enumerated bits, so the counter walks the mask subsets in ascending order.
    logic [XLen-1:0] cx_next;
    logic [YLen-1:0] cy_next;
    logic            beat_last;
    assign cx_next   = ((cx_q | ~mx_q) + XOne) & mx_q;
    assign cy_next   = ((cy_q | ~my_q) + YOne) & my_q;
    assign beat_last = (cx_q == mx_q) && (cy_q == my_q);

    always_comb begin
        out_addr_o                    = base_q;
        out_addr_o[XOffset+:XLen]     = (base_q[XOffset+:XLen] & ~mx_q) | cx_q;
        out_addr_o[YOffset+:YLen]     = (base_q[YOffset+:YLen] & ~my_q) | cy_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
            base_q  <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                Idle: begin
                    if (in_valid_i) begin
                        if (legal) begin
                            state_q <= Emit;
                            base_q  <= in_addr_i;
                            mx_q    <= in_mx;
                            my_q    <= in_my;
                            cx_q    <= '0;
                            cy_q    <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                Emit: begin
                    if (out_ready_i) begin
                        if (beat_last) begin
                            state_q <= Idle;
                        end else if (cy_q == my_q) begin
                            cy_q <= '0;
                            cx_q <= cx_next;
                        end else begin
                            cy_q <= cy_next;
                        end
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

    assign in_ready_o  = (state_q == Idle);
    assign out_valid_o = (state_q == Emit);
    assign busy_o      = (state_q == Emit);
    assign out_last_o  = (state_q == Emit) && beat_last;
    assign err_o       = err_q;

endmodule
